// File: rtl/clk_div_sched.sv
// Programmable integer clock divider: emits a one-cycle clk_en and a square clk_out every cur_div cycles.
// Ratio changes arrive over a pulse/ack handshake and take effect only on a period boundary.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_en,
  output logic             clk_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_nxt_div;
  logic             r_ack;
  logic             r_err;

  logic             w_accept;
  logic             w_valid;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_apply_val;
  logic             w_load_nxt;
  logic [CNT_W-1:0] w_cnt_next;

  // A request is only looked at when nothing is already pending.
  assign w_accept = div_req && (r_state != S_PEND);
  assign w_valid  = (div_val >= CNT_W'(2));
  assign w_wrap   = (r_state != S_IDLE) && (r_cnt == r_cur_div - CNT_W'(1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_next = S_RUN;
      S_RUN: begin
        if (!enable)
          w_state_next = S_IDLE;
        else if (w_accept && w_valid && !w_wrap)
          w_state_next = S_PEND;
      end
      S_PEND: begin
        if (!enable)
          w_state_next = S_IDLE;
        else if (w_wrap)
          w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Ratio update: a pending value wins at the wrap or on stop; a fresh one applies when no period is in progress.
  always_comb begin
    w_apply     = 1'b0;
    w_apply_val = div_val;
    w_load_nxt  = 1'b0;
    if (r_state == S_PEND) begin
      if (!enable || w_wrap) begin
        w_apply     = 1'b1;
        w_apply_val = r_nxt_div;
      end
    end else if (w_accept && w_valid) begin
      if (r_state == S_IDLE || !enable || w_wrap)
        w_apply = 1'b1;
      else
        w_load_nxt = 1'b1;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt + CNT_W'(1);
    if (r_state == S_IDLE || !enable || w_wrap)
      w_cnt_next = '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt     <= '0;
      r_cur_div <= CNT_W'(DIV_DEFAULT);
      r_nxt_div <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ack <= w_apply || (w_accept && !w_valid);
      r_err <= w_accept && !w_valid;
      if (w_apply)
        r_cur_div <= w_apply_val;
      if (w_load_nxt)
        r_nxt_div <= div_val;
    end
  end

  always_comb begin
    clk_en  = (r_state != S_IDLE) && (r_cnt == '0);
    clk_out = (r_state != S_IDLE) && (r_cnt < (r_cur_div >> 1));
    busy    = (r_state == S_PEND);
    div_ack = r_ack;
    div_err = r_err;
    cur_div = r_cur_div;
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched: directed scenarios plus a randomized run against a period-level model.
module tb_clk_div_sched;

  localparam int CNT_W = 8;
  localparam int DEF   = 5;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             enable  = 1'b0;
  logic             div_req = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_ack, div_err, busy, clk_en, clk_out;
  logic [CNT_W-1:0] cur_div;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_sched #(.CNT_W(CNT_W), .DIV_DEFAULT(DEF)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .div_req(div_req),
    .div_val(div_val), .div_ack(div_ack), .div_err(div_err), .busy(busy),
    .cur_div(cur_div), .clk_en(clk_en), .clk_out(clk_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: position inside the current period, ratio in force, and a queue holding at most one pending ratio.
  bit m_run;
  int m_phase;
  int m_ratio;
  int m_pend_q[$];
  bit m_ack, m_err;

  function automatic void model_reset();
    m_run = 0; m_phase = 0; m_ratio = DEF; m_pend_q.delete(); m_ack = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit en, bit req, int val);
    bit acc  = req && (m_pend_q.size() == 0);
    bit ok   = (val >= 2);
    bit wrap = m_run && (m_phase == m_ratio - 1);
    m_ack = 0; m_err = 0;
    if (acc && !ok) begin m_ack = 1; m_err = 1; end
    if (!m_run) begin
      if (acc && ok) begin m_ratio = val; m_ack = 1; end
      m_run = en; m_phase = 0;
    end else if (!en) begin
      if (m_pend_q.size() != 0) begin m_ratio = m_pend_q.pop_front(); m_ack = 1; end
      if (acc && ok) begin m_ratio = val; m_ack = 1; end
      m_run = 0; m_phase = 0;
    end else begin
      m_phase = wrap ? 0 : m_phase + 1;
      if (wrap && m_pend_q.size() != 0) begin
        m_ratio = m_pend_q.pop_front(); m_ack = 1;
      end else if (acc && ok) begin
        if (wrap) begin m_ratio = val; m_ack = 1; end
        else m_pend_q.push_back(val);
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] r = m_ratio[7:0];
    return {m_run && m_phase == 0, m_run && m_phase < m_ratio / 2, m_ack, m_err,
            m_pend_q.size() != 0, r};
  endfunction

  function automatic logic [12:0] act_vec();
    return {clk_en, clk_out, div_ack, div_err, busy, cur_div};
  endfunction

  // Drive one cycle of inputs, advance one edge, and land 1 time unit after it.
  task automatic tick(bit en, bit req, int val);
    enable = en; div_req = req; div_val = val[CNT_W-1:0];
    @(posedge sys_clk);
    model_step(en, req, val);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; enable = 0; div_req = 0; div_val = '0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (act_vec() !== 13'({5'b0, 8'(DEF)})) $display("FAIL reset_state got=%h exp=%h", act_vec(), 13'({5'b0, 8'(DEF)}));
    else n_pass++;
  endtask

  task automatic test_default_run();
    int pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1, 0, 0);
      pulses += clk_en;
      n_checks++;
      if (clk_out !== ((i % 5) < 2) || clk_en !== ((i % 5) == 0) || cur_div !== 8'd5)
        $display("FAIL default_run i=%0d got en=%b out=%b div=%0d exp en=%b out=%b div=5", i, clk_en, clk_out, cur_div, (i % 5) == 0, (i % 5) < 2);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 6) $display("FAIL default_pulses got=%0d exp=6", pulses);
    else n_pass++;
  endtask

  task automatic test_idle_change();
    do_reset();
    tick(0, 1, 2);
    n_checks++;
    if (div_ack !== 1'b1 || div_err !== 1'b0 || cur_div !== 8'd2)
      $display("FAIL idle_change got ack=%b err=%b div=%0d exp ack=1 err=0 div=2", div_ack, div_err, cur_div);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if (clk_out !== (i % 2 == 0) || clk_en !== (i % 2 == 0))
        $display("FAIL div2_run i=%0d got en=%b out=%b exp=%b", i, clk_en, clk_out, i % 2 == 0);
      else n_pass++;
    end
  endtask

  task automatic test_pending_change();
    int busy_cnt = 0, ack_cnt = 0, k = -1;
    do_reset();
    tick(1, 0, 0);
    // Request sampled on the edge that moves cnt to 1; a second one arrives while busy.
    for (int j = 0; j < 21; j++) begin
      tick(1, j == 0 || j == 2, (j == 0) ? 8 : 3);
      busy_cnt += busy;
      ack_cnt  += div_ack;
      if (div_ack) k = 0;
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL pend_model j=%0d got=%h exp=%h", j, act_vec(), exp_vec());
      else n_pass++;
      if (k >= 0) begin
        n_checks++;
        if (clk_out !== ((k % 8) < 4) || clk_en !== ((k % 8) == 0) || cur_div !== 8'd8)
          $display("FAIL div8_pattern k=%0d got en=%b out=%b div=%0d", k, clk_en, clk_out, cur_div);
        else n_pass++;
        k++;
      end
    end
    n_checks++;
    if (busy_cnt !== 4) $display("FAIL busy_cycles got=%0d exp=4", busy_cnt);
    else n_pass++;
    n_checks++;
    if (ack_cnt !== 1) $display("FAIL pend_ack_count got=%0d exp=1", ack_cnt);
    else n_pass++;
  endtask

  task automatic test_reject();
    int vals[2] = '{1, 0};
    do_reset();
    tick(1, 0, 0); tick(1, 0, 0);
    foreach (vals[v]) begin
      tick(1, 1, vals[v]);
      n_checks++;
      if (div_ack !== 1'b1 || div_err !== 1'b1 || cur_div !== 8'd5 || busy !== 1'b0)
        $display("FAIL reject val=%0d got ack=%b err=%b div=%0d busy=%b exp ack=1 err=1 div=5 busy=0", vals[v], div_ack, div_err, cur_div, busy);
      else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL reject_period i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_abort_pend();
    do_reset();
    tick(1, 0, 0);
    tick(1, 1, 3);
    tick(1, 0, 0);
    tick(0, 0, 0);
    n_checks++;
    if (clk_out !== 1'b0 || clk_en !== 1'b0 || cur_div !== 8'd3 || div_ack !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_pend got out=%b en=%b div=%0d ack=%b busy=%b exp out=0 en=0 div=3 ack=1 busy=0", clk_out, clk_en, cur_div, div_ack, busy);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if (clk_en !== (i % 3 == 0) || clk_out !== (i % 3 == 0))
        $display("FAIL div3_run i=%0d got en=%b out=%b exp=%b", i, clk_en, clk_out, i % 3 == 0);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int acks = 0;
    do_reset();
    tick(0, 1, 7);
    tick(1, 0, 0); tick(1, 0, 0);
    tick(1, 1, 9);
    tick(1, 0, 0);
    #2 sys_rst = 1'b1;
    #1;
    n_checks++;
    if (act_vec() !== 13'({5'b0, 8'(DEF)})) $display("FAIL async_reset got=%h exp=%h", act_vec(), 13'({5'b0, 8'(DEF)}));
    else n_pass++;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick(i >= 4, 0, 0);
      acks += div_ack;
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL post_reset i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (acks !== 0) $display("FAIL post_reset_ack got=%0d exp=0", acks);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit en  = ($urandom_range(0, 19) != 0);
      bit req = ($urandom_range(0, 6) == 0);
      int val = $urandom_range(0, 12);
      tick(en, req, val);
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL random i=%0d en=%b req=%b val=%0d got=%h exp=%h", i, en, req, val, act_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_run();
    test_idle_change();
    test_pending_change();
    test_reject();
    test_abort_pend();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
# clk_div_sched

Run-time controller for the design's integer clock dividers. It produces a single-cycle clock-enable pulse and a square-wave `clk_out` at a programmable ratio N of `sys_clk`, with a default ratio of 5. It accepts ratio-change requests over a pulse/ack handshake and applies each change only at a period boundary, so downstream logic never sees a truncated or stretched period. It sits between the control/register logic and every block that consumes the divided clock as an enable.

## Interface
- `CNT_W`, 8: width of the ratio and the period counter.
- `DIV_DEFAULT`, 5: ratio after reset. Must satisfy 2 ≤ DIV_DEFAULT ≤ 2^CNT_W−1.
- `sys_clk`, in, 1: system clock. The only clock in the block.
- `sys_rst`, in, 1: reset, asynchronous and active-high.
- `enable`, in, 1: run request. Level-sensitive.
- `div_req`, in, 1: ratio-change request. Single-cycle pulse.
- `div_val`, in, CNT_W: requested ratio. Sampled in the cycle `div_req` is high.
- `div_ack`, out, 1: one-cycle pulse when a request completes, whether applied or rejected.
- `div_err`, out, 1: one-cycle pulse, coincident with `div_ack`, when the request was rejected (`div_val` < 2).
- `busy`, out, 1: high while a valid request is pending.
- `cur_div`, out, CNT_W: ratio currently in force.
- `clk_en`, out, 1: high for exactly the first cycle of each period.
- `clk_out`, out, 1: high for floor(N/2) cycles at the start of each period, then low for the rest of the period.

## Operation
- The block has three states: IDLE, RUN and PEND. PEND behaves as RUN and additionally holds a pending ratio `nxt_div`.
- Transitions:
  - IDLE → RUN on the first edge with `enable`=1. The counter `cnt` is set to 0.
  - RUN/PEND → IDLE on any edge with `enable`=0. This may abort mid-period. `cnt` is set to 0.
  - RUN → PEND when a valid request is accepted and the current cycle is not the wrap cycle.
  - PEND → RUN at the wrap cycle.
- Counting: in RUN/PEND, `cnt` increments each cycle. It wraps to 0 when `cnt` = `cur_div`−1; that cycle is the wrap cycle. Arithmetic is unsigned CNT_W-bit and `cnt` never exceeds `cur_div`−1.
- Outputs are decoded from registers only, so there is no combinational path from any input to any output:
  - `clk_en` = running ∧ (`cnt`=0).
  - `clk_out` = running ∧ (`cnt` < `cur_div`>>1).
  - In IDLE both are 0.
- Request acceptance:
  - `div_req` is ignored while `busy`=1. There is no queueing and no ack for an ignored request.
  - `div_val` < 2: the request is rejected. `div_ack` and `div_err` pulse in the next cycle, and neither the state nor `cur_div` changes.
  - Valid request in IDLE: `cur_div` ← `div_val` at that edge. `div_ack` pulses in the next cycle.
  - Valid request in RUN during the wrap cycle: applied at that same edge, so the next period uses the new N. `div_ack` pulses in the next cycle.
  - Valid request in RUN at any other time: `nxt_div` ← `div_val` and `busy` ← 1. At the wrap edge, `cur_div` ← `nxt_div` and `busy` ← 0, and `div_ack` pulses in the following cycle.
- Enable dropped while in PEND: the pending ratio is applied on entry to IDLE, with `busy` ← 0 and `div_ack` pulsing in the next cycle.
- Reset values: `cur_div`=DIV_DEFAULT, state IDLE, `cnt`=0, `nxt_div`=0. `clk_en`, `clk_out`, `div_ack`, `div_err` and `busy` are all 0. A pending request is discarded without an ack.

## Timing
- Start latency: `enable` sampled high at edge k gives `clk_en`=1 and `clk_out`=1 in the cycle after edge k.
- Period: exactly `cur_div` cycles.
  - N=2: `clk_out` is high 1 cycle, low 1 cycle.
  - N=5: high 2 cycles, low 3 cycles.
- `div_ack` latency from `div_req`:
  - 1 cycle for IDLE, wrap-cycle or rejected requests.
  - Otherwise, from 1 cycle after the next wrap edge up to `cur_div` cycles after `div_req`.
- A ratio change never alters the period in progress. The first `clk_en` at the new ratio occurs in the cycle the ack pulses.
- Stop latency: `enable` low at edge k gives `clk_en`=0 and `clk_out`=0 in the cycle after edge k.

## Test plan
- Reset, then hold `enable`=1 for 30 cycles. Required: `clk_en` pulses every 5 cycles, 6 pulses in total; `clk_out` follows the pattern 11000 per period; `cur_div`=5.
- In IDLE, `div_req` with `div_val`=2. Required: `div_ack` pulses 1 cycle later, `div_err`=0, `cur_div`=2. Then with `enable`=1: `clk_out` toggles every cycle and `clk_en` is high every other cycle.
- Running at N=5, `div_req` with `div_val`=8 at `cnt`=1. Required: `busy`=1 for 4 cycles; the current period completes with 5 cycles; `div_ack` pulses coincident with the first `clk_en`; subsequent periods are 8 cycles with `clk_out` pattern 11110000. A second `div_req` issued while `busy`=1 is ignored and produces no ack.
- `div_req` with `div_val`=1 and with `div_val`=0. Required: for each, `div_ack` and `div_err` pulse together 1 cycle later, and `cur_div` and the period are unchanged.
- Drive `enable` low at `cnt`=2 while in PEND (`div_val`=3). Required: 1 cycle later `clk_out`=0, `clk_en`=0, `cur_div`=3 and `div_ack` pulses. Re-enable: periods are 3 cycles.
- Assert `sys_rst` asynchronously mid-period while PEND. Required: all outputs go to 0 immediately, `cur_div` returns to 5, and no `div_ack` appears after reset release.
